// File: rtl/mips_dmem_bridge.sv
// +----------------------------------------------------------------------------+
// | Module  : mips_dmem_bridge                                                 |
// | Desc    : Core data-memory port to valid/ready bus bridge with posted      |
// |           write buffer and blocking single-outstanding loads.              |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module mips_dmem_bridge #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            MemRead,
  input  logic                            MemWrite,
  input  logic [ADDR_W-1:0]               Address,
  input  logic [DATA_W-1:0]               WriteData,
  output logic [DATA_W-1:0]               ReadData,
  output logic                            Stall,
  output logic                            bus_req_valid,
  input  logic                            bus_req_ready,
  output logic                            bus_req_we,
  output logic [ADDR_W-1:0]               bus_req_addr,
  output logic [DATA_W-1:0]               bus_req_wdata,
  input  logic                            bus_rsp_valid,
  input  logic [DATA_W-1:0]               bus_rsp_rdata,
  output logic [$clog2(WBUF_DEPTH):0]     wbuf_count
);

  localparam int c_PTR_W = $clog2(WBUF_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    RD_DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [DATA_W-1:0]   r_read_data;

  logic [ADDR_W-1:0]   r_fifo_addr [WBUF_DEPTH];
  logic [DATA_W-1:0]   r_fifo_data [WBUF_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_wr_valid;
  logic                w_rd_start;

  assign w_full     = (r_count == c_CNT_W'(WBUF_DEPTH));
  assign w_empty    = (r_count == '0);
  // Push is gated by full alone; a same-cycle pop does not make room.
  assign w_push     = MemWrite & ~w_full;
  assign w_wr_valid = (r_state == IDLE) & ~w_empty;
  assign w_pop      = w_wr_valid & bus_req_ready;
  assign w_rd_start = (r_state == IDLE) & MemRead & ~MemWrite & w_empty;

  // Write-buffer storage needs no reset: only entries below r_count are visible.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= Address;
      r_fifo_data[r_wr_ptr] <= WriteData;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_rd_addr   <= '0;
      r_read_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_rd_start) r_rd_addr <= Address;
      if ((r_state == RD_WAIT) && bus_rsp_valid) r_read_data <= bus_rsp_rdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_rd_start)    w_state_nxt = RD_REQ;
      RD_REQ:  if (bus_req_ready) w_state_nxt = RD_WAIT;
      RD_WAIT: if (bus_rsp_valid) w_state_nxt = RD_DONE;
      RD_DONE:                    w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  // Bus outputs depend only on state, FIFO contents and the latched read address.
  assign bus_req_valid = w_wr_valid | (r_state == RD_REQ);
  assign bus_req_we    = w_wr_valid;
  assign bus_req_addr  = (r_state == RD_REQ) ? r_rd_addr : r_fifo_addr[r_rd_ptr];
  assign bus_req_wdata = r_fifo_data[r_rd_ptr];

  assign Stall      = (MemRead & ~MemWrite & (r_state != RD_DONE)) | (MemWrite & w_full);
  assign ReadData   = r_read_data;
  assign wbuf_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_mips_dmem_bridge.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_mips_dmem_bridge                                              |
// | Desc    : Self-checking bench: core driver, bus memory responder, ordering |
// |           scoreboard and reset scenarios for mips_dmem_bridge.             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mips_dmem_bridge;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int WBUF_DEPTH = 4;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              MemRead = 1'b0, MemWrite = 1'b0;
  logic [ADDR_W-1:0] Address = '0;
  logic [DATA_W-1:0] WriteData = '0;
  logic [DATA_W-1:0] ReadData;
  logic              Stall;
  logic              bus_req_valid, bus_req_we;
  logic              bus_req_ready = 1'b0;
  logic [ADDR_W-1:0] bus_req_addr;
  logic [DATA_W-1:0] bus_req_wdata;
  logic              bus_rsp_valid = 1'b0;
  logic [DATA_W-1:0] bus_rsp_rdata = '0;
  logic [2:0]        wbuf_count;

  always #5 CLK = ~CLK;

  mips_dmem_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WBUF_DEPTH(WBUF_DEPTH)) dut (
    .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_we(bus_req_we), .bus_req_addr(bus_req_addr),
    .bus_req_wdata(bus_req_wdata), .bus_rsp_valid(bus_rsp_valid),
    .bus_rsp_rdata(bus_rsp_rdata), .wbuf_count(wbuf_count)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  int   checks = 0;
  int   errors = 0;
  txn_t exp_q[$];                       // program-order bus transactions
  logic [31:0] ref_mem [logic [31:0]];  // architectural memory seen by the core
  logic [31:0] bus_mem [logic [31:0]];  // memory behind the bus

  int          ready_mode = 0;          // 0 random, 1 always ready, 2 never ready
  int          max_delay  = 0;
  bit          auto_bus   = 1'b0;
  bit          junk_en    = 1'b0;
  bit          rsp_pending = 1'b0;
  int          rsp_cnt    = 0;
  logic [31:0] rsp_addr   = '0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] bus_read(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_val(a);
  endfunction

  // Bus-side memory model and ordering scoreboard; acts on the falling edge.
  initial begin
    txn_t e;
    forever begin
      @(negedge CLK);
      if (auto_bus) begin
        bus_rsp_valid = 1'b0;
        if (rsp_pending) begin
          if (rsp_cnt == 0) begin
            bus_rsp_valid = 1'b1;
            bus_rsp_rdata = bus_read(rsp_addr);
            rsp_pending   = 1'b0;
          end else rsp_cnt--;
        end else if (junk_en && $urandom_range(0, 3) == 0) begin
          bus_rsp_valid = 1'b1;
          bus_rsp_rdata = $urandom;
        end
        case (ready_mode)
          1:       bus_req_ready = 1'b1;
          2:       bus_req_ready = 1'b0;
          default: bus_req_ready = 1'($urandom_range(0, 1));
        endcase
        if (bus_req_valid === 1'b1 && bus_req_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL bus_order: unexpected request we=%0b addr=%h, required none", bus_req_we, bus_req_addr);
          end else begin
            e = exp_q.pop_front();
            if (bus_req_we !== e.we || bus_req_addr !== e.addr || (e.we && bus_req_wdata !== e.data)) begin
              errors++;
              $display("FAIL bus_order: got we=%0b addr=%h wdata=%h, required we=%0b addr=%h wdata=%h",
                       bus_req_we, bus_req_addr, bus_req_wdata, e.we, e.addr, e.data);
            end
          end
          if (bus_req_we) bus_mem[bus_req_addr] = bus_req_wdata;
          else begin
            rsp_pending = 1'b1;
            rsp_cnt     = $urandom_range(0, max_delay);
            rsp_addr    = bus_req_addr;
          end
        end
      end
    end
  end

  // Core-side drivers: start and end just after a rising edge.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input bit with_read,
                          output int stalls, output bit ok);
    txn_t t;
    stalls = 0; ok = 1'b0;
    MemWrite = 1'b1; MemRead = with_read; Address = a; WriteData = d;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge CLK);
      if (Stall === 1'b0) ok = 1'b1; else stalls++;
      @(posedge CLK); #1;
    end
    if (ok) begin
      ref_mem[a] = d;
      t = '{we: 1'b1, addr: a, data: d};
      exp_q.push_back(t);
    end
    MemWrite = 1'b0; MemRead = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, output int stalls, output logic [31:0] got, output bit ok);
    txn_t t;
    stalls = 0; ok = 1'b0; got = '0;
    t = '{we: 1'b0, addr: a, data: 32'h0};
    exp_q.push_back(t);
    MemRead = 1'b1; MemWrite = 1'b0; Address = a;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge CLK);
      if (Stall === 1'b0) begin ok = 1'b1; got = ReadData; end
      else stalls++;
      @(posedge CLK); #1;
    end
    MemRead = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge CLK);
      if (wbuf_count === 3'd0 && exp_q.size() == 0 && !rsp_pending) ok = 1'b1;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    checks++;
    if (ReadData !== 32'h0 || bus_req_valid !== 1'b0 || wbuf_count !== 3'd0 || Stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ReadData=%h valid=%b count=%0d Stall=%b, required 0/0/0/0",
               ReadData, bus_req_valid, wbuf_count, Stall);
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    auto_bus = 1'b1;
  endtask

  task automatic test_single_load();
    int st; logic [31:0] got; bit ok;
    ready_mode = 1; max_delay = 0; junk_en = 1'b0;
    bus_mem[32'h10] = 32'hDEAD_BEEF; ref_mem[32'h10] = 32'hDEAD_BEEF;
    do_load(32'h10, st, got, ok);
    checks++;
    if (!ok || got !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_load_data: ok=%0b got=%h, required DEADBEEF", ok, got);
    end
    checks++;
    if (st != 3) begin errors++; $display("FAIL single_load_latency: stalls=%0d, required 3", st); end
    @(negedge CLK);
    checks++;
    if (bus_req_valid !== 1'b0 || Stall !== 1'b0) begin
      errors++; $display("FAIL single_load_idle: valid=%b Stall=%b, required 0/0", bus_req_valid, Stall);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_back_to_back();
    int st1, st2; logic [31:0] g1, g2; bit ok1, ok2;
    ready_mode = 1; max_delay = 0;
    do_load(32'h40, st1, g1, ok1);
    do_load(32'h41, st2, g2, ok2);
    checks++;
    if (!ok1 || !ok2 || g1 !== ref_read(32'h40) || g2 !== ref_read(32'h41) || st1 != 3 || st2 != 3) begin
      errors++;
      $display("FAIL back_to_back_loads: data %h/%h stalls %0d/%0d, required %h/%h stalls 3/3",
               g1, g2, st1, st2, ref_read(32'h40), ref_read(32'h41));
    end
  endtask

  task automatic test_posted_stores();
    int st; bit ok;
    ready_mode = 2;
    for (int i = 0; i < 4; i++) begin
      do_store(32'(i), 32'hA0 + 32'(i), 1'b0, st, ok);
      checks++;
      if (!ok || st != 0) begin errors++; $display("FAIL posted_store_%0d: stalls=%0d, required 0", i, st); end
    end
    @(negedge CLK);
    checks++;
    if (wbuf_count !== 3'd4 || bus_req_valid !== 1'b1 || bus_req_we !== 1'b1 ||
        bus_req_addr !== 32'h0 || bus_req_wdata !== 32'hA0) begin
      errors++;
      $display("FAIL wbuf_full: count=%0d valid=%b we=%b addr=%h wdata=%h, required 4/1/1/0/A0",
               wbuf_count, bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata);
    end
    @(posedge CLK); #1;
    MemWrite = 1'b1; Address = 32'h4; WriteData = 32'hA4;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (Stall !== 1'b1 || wbuf_count !== 3'd4) begin
        errors++; $display("FAIL full_stall_%0d: Stall=%b count=%0d, required 1/4", i, Stall, wbuf_count);
      end
      @(posedge CLK); #1;
    end
    ready_mode = 1;
    do_store(32'h4, 32'hA4, 1'b0, st, ok);
    checks++;
    if (!ok || st != 1) begin errors++; $display("FAIL full_release: stalls=%0d, required 1", st); end
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL store_drain: count=%0d, required 0", wbuf_count); end
  endtask

  task automatic test_store_then_load();
    int st; logic [31:0] got; bit ok;
    ready_mode = 0; max_delay = 2;
    do_store(32'h20, 32'h55, 1'b0, st, ok);
    do_load(32'h20, st, got, ok);
    checks++;
    if (!ok || got !== 32'h55 || bus_mem[32'h20] !== 32'h55) begin
      errors++; $display("FAIL store_then_load: got=%h busmem=%h, required 55/55", got, bus_mem[32'h20]);
    end
  endtask

  task automatic test_backpressure();
    txn_t t; bit ok, bad;
    ready_mode = 2;
    t = '{we: 1'b0, addr: 32'h88, data: 32'h0};
    exp_q.push_back(t);
    MemRead = 1'b1; Address = 32'h88;
    @(posedge CLK); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      bad = (bus_req_valid !== 1'b1 || bus_req_we !== 1'b0 || bus_req_addr !== 32'h88 || Stall !== 1'b1);
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL backpressure_%0d: valid=%b we=%b addr=%h Stall=%b, required 1/0/88/1",
                 i, bus_req_valid, bus_req_we, bus_req_addr, Stall);
      end
      @(posedge CLK); #1;
    end
    ready_mode = 1;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge CLK);
      if (Stall === 1'b0) ok = 1'b1;
      @(posedge CLK); #1;
    end
    MemRead = 1'b0;
    checks++;
    if (!ok || ReadData !== ref_read(32'h88)) begin
      errors++; $display("FAIL backpressure_data: ok=%0b got=%h, required %h", ok, ReadData, ref_read(32'h88));
    end
  endtask

  task automatic test_simul_rw();
    int st; bit ok, bad;
    ready_mode = 2;
    do_store(32'h30, 32'hC3C3, 1'b1, st, ok);
    @(negedge CLK);
    checks++;
    if (!ok || st != 0 || wbuf_count !== 3'd1 || bus_req_we !== 1'b1 || bus_req_addr !== 32'h30) begin
      errors++;
      $display("FAIL simul_rw_push: stalls=%0d count=%0d we=%b addr=%h, required 0/1/1/30",
               st, wbuf_count, bus_req_we, bus_req_addr);
    end
    @(posedge CLK); #1;
    ready_mode = 1;
    wait_drain(ok);
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (bus_req_valid !== 1'b0) bad = 1'b1;
      @(posedge CLK); #1;
    end
    checks++;
    if (!ok || bad) begin errors++; $display("FAIL simul_rw_noread: drained=%0b stray_valid=%0b, required 1/0", ok, bad); end
  endtask

  task automatic test_random();
    int st, kind, lerr; logic [31:0] a, d, got; bit ok;
    ready_mode = 0; max_delay = 3; junk_en = 1'b1; lerr = 0;
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 9);
      a    = 32'($urandom_range(0, 7)) + 32'h100;
      d    = $urandom;
      if (kind <= 4) do_store(a, d, 1'b0, st, ok);
      else if (kind == 8) do_store(a, d, 1'b1, st, ok);
      else if (kind == 9) begin @(posedge CLK); #1; end
      else begin
        do_load(a, st, got, ok);
        checks++;
        if (!ok || got !== ref_read(a)) begin
          errors++; $display("FAIL random_load_%0d: addr=%h got=%h, required %h", i, a, got, ref_read(a));
        end
      end
      if ((kind <= 4 || kind == 8) && !ok) lerr++;
    end
    junk_en = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok || lerr != 0) begin
      errors++; $display("FAIL random_drain: drained=%0b store_timeouts=%0d left=%0d, required 1/0/0", ok, lerr, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    auto_bus = 1'b0; rsp_pending = 1'b0; bus_rsp_valid = 1'b0; bus_req_ready = 1'b1;
    MemRead = 1'b1; Address = 32'h44;
    @(posedge CLK); @(posedge CLK); #2;
    RST = 1'b0; MemRead = 1'b0; bus_req_ready = 1'b0;
    #1;
    checks++;
    if (ReadData !== 32'h0 || wbuf_count !== 3'd0 || bus_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_rd_wait: ReadData=%h count=%0d valid=%b, required 0/0/0", ReadData, wbuf_count, bus_req_valid);
    end
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h1234_5678;
    @(posedge CLK); #1;
    bus_rsp_valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (ReadData !== 32'h0 || bus_req_valid !== 1'b0 || Stall !== 1'b0) begin
      errors++;
      $display("FAIL late_rsp_ignored: ReadData=%h valid=%b Stall=%b, required 0/0/0", ReadData, bus_req_valid, Stall);
    end
    @(posedge CLK); #1;
    MemWrite = 1'b1; Address = 32'h50; WriteData = 32'h1;
    @(posedge CLK); #1;
    Address = 32'h51; WriteData = 32'h2;
    @(posedge CLK); #1;
    MemWrite = 1'b0;
    @(negedge CLK);
    checks++;
    if (wbuf_count !== 3'd2 || bus_req_valid !== 1'b1 || bus_req_addr !== 32'h50) begin
      errors++;
      $display("FAIL pre_reset_fill: count=%0d valid=%b addr=%h, required 2/1/50", wbuf_count, bus_req_valid, bus_req_addr);
    end
    RST = 1'b0;
    #1;
    checks++;
    if (wbuf_count !== 3'd0 || bus_req_valid !== 1'b0) begin
      errors++; $display("FAIL reset_wbuf: count=%0d valid=%b, required 0/0", wbuf_count, bus_req_valid);
    end
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    test_reset();
    test_single_load();
    test_back_to_back();
    test_posted_stores();
    test_store_then_load();
    test_backpressure();
    test_simul_rw();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
